// File: rtl/cgra_pkg.sv
// Shared CGRA datapath width plus the column memory responder's FSM type and grant-latency limits.
package cgra_pkg;

    localparam int unsigned DP_WIDTH    = 32;
    localparam int unsigned GNT_LAT_MAX = 7;
    localparam int unsigned GNT_CNT_W   = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } resp_state_t;

    // Pointer post-increment by one word, wrapping modulo 2^DP_WIDTH.
    function automatic logic [DP_WIDTH-1:0] ptr_step(input logic [DP_WIDTH-1:0] ptr);
        return ptr + DP_WIDTH'(4);
    endfunction

endpackage

// File: rtl/cgra_col_mem_responder_if.sv
// Column request / response bus between a CGRA column (master) and the memory responder (slave).
interface cgra_col_mem_responder_if;
    import cgra_pkg::*;

    logic                data_req_i;
    logic                data_wen_i;
    logic                data_ind_i;
    logic [DP_WIDTH-1:0] data_add_i;
    logic [DP_WIDTH-1:0] data_wdata_i;
    logic                ptr_load_i;
    logic [DP_WIDTH-1:0] ptr_val_i;
    logic                data_gnt_o;
    logic                data_rvalid_o;
    logic [DP_WIDTH-1:0] data_rdata_o;

    modport slave (
        input  data_req_i, data_wen_i, data_ind_i, data_add_i, data_wdata_i,
        input  ptr_load_i, ptr_val_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o
    );

    modport master (
        output data_req_i, data_wen_i, data_ind_i, data_add_i, data_wdata_i,
        output ptr_load_i, ptr_val_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o
    );

endinterface

// File: rtl/cgra_resp_mem.sv
// Single-port MEM_DEPTH x DP_WIDTH storage with synchronous write and registered read port.
module cgra_resp_mem
    import cgra_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic                         re_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr_i,
    input  logic [DP_WIDTH-1:0]          wdata_i,
    output logic [DP_WIDTH-1:0]          rdata_o
);

    logic [DP_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DP_WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Every access updates the read register; non-reads (writes, dropped reads) load zero.
    always_comb begin
        rdata_d = rdata_q;
        if (req_i) begin
            rdata_d = re_i ? mem_q[addr_i] : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cgra_col_mem_responder.sv
// Column memory responder: grant FSM with optional wait latency, auto-incrementing pointer, local RAM.
// Define CGRA_RESP_RANGE_CHK_EN to add the sticky range_err_o flag and drop out-of-range accesses.
module cgra_col_mem_responder
    import cgra_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned GNT_LATENCY = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    cgra_col_mem_responder_if.slave        bus_if
`ifdef CGRA_RESP_RANGE_CHK_EN
    ,
    output logic                           range_err_o
`endif
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    resp_state_t          state_q, state_d;
    logic [GNT_CNT_W-1:0] cnt_q, cnt_d;
    logic [DP_WIDTH-1:0]  ptr_q, ptr_d;
    logic [DP_WIDTH-1:0]  eff_addr;
    logic                 grant_raw;
    logic                 grant;
    logic                 is_write;
    logic                 in_range;
    logic                 unused_addr;

    assign eff_addr = bus_if.data_ind_i ? bus_if.data_add_i : ptr_q;
    assign is_write = ~bus_if.data_wen_i;

`ifdef CGRA_RESP_RANGE_CHK_EN
    logic range_err_q, range_err_d;

    assign in_range    = (eff_addr >> (AW + 2)) == '0;
    assign unused_addr = ^eff_addr[1:0];
    assign range_err_d = range_err_q | (grant & ~in_range);
    assign range_err_o = range_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end
`else
    // Upper address bits alias onto the word array.
    assign in_range    = 1'b1;
    assign unused_addr = ^{eff_addr[DP_WIDTH-1:AW+2], eff_addr[1:0]};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_raw = 1'b0;
        unique case (state_q)
            // RESP behaves like IDLE so grants can issue back-to-back.
            StIdle, StResp: begin
                state_d = StIdle;
                if (bus_if.data_req_i) begin
                    if (GNT_LATENCY == 0) begin
                        grant_raw = 1'b1;
                        state_d   = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = GNT_CNT_W'(GNT_LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (!bus_if.data_req_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    grant_raw = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q - GNT_CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // No grant may escape while reset is held, so nothing is written during reset.
    assign grant = grant_raw & ~rst_i;

    always_comb begin
        ptr_d = ptr_q;
        if (grant && !bus_if.data_ind_i) begin
            ptr_d = ptr_step(ptr_q);
        end
        if (bus_if.ptr_load_i) begin
            ptr_d = bus_if.ptr_val_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    cgra_resp_mem #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (grant),
        .we_i    (is_write & in_range),
        .re_i    (~is_write & in_range),
        .addr_i  (eff_addr[AW+1:2]),
        .wdata_i (bus_if.data_wdata_i),
        .rdata_o (bus_if.data_rdata_o)
    );

    assign bus_if.data_gnt_o    = grant;
    assign bus_if.data_rvalid_o = (state_q == StResp);

endmodule

// File: tb/tb_cgra_col_mem_responder.sv
// Bench: two responders (grant latency 0 and 3) share one stimulus stream; a per-instance
// transaction-level model predicts grants, responses and memory contents.
module tb_cgra_col_mem_responder;
    import cgra_pkg::*;

    localparam int unsigned MEM_DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req, wen, ind, pload;
    logic [31:0] add, wdata, pval;

    cgra_col_mem_responder_if bus0 ();
    cgra_col_mem_responder_if bus3 ();

    assign bus0.data_req_i   = req;
    assign bus0.data_wen_i   = wen;
    assign bus0.data_ind_i   = ind;
    assign bus0.data_add_i   = add;
    assign bus0.data_wdata_i = wdata;
    assign bus0.ptr_load_i   = pload;
    assign bus0.ptr_val_i    = pval;
    assign bus3.data_req_i   = req;
    assign bus3.data_wen_i   = wen;
    assign bus3.data_ind_i   = ind;
    assign bus3.data_add_i   = add;
    assign bus3.data_wdata_i = wdata;
    assign bus3.ptr_load_i   = pload;
    assign bus3.ptr_val_i    = pval;

    logic [1:0]  gnt_w, rvalid_w;
    logic [31:0] rdata_w [2];
    assign gnt_w      = {bus3.data_gnt_o, bus0.data_gnt_o};
    assign rvalid_w   = {bus3.data_rvalid_o, bus0.data_rvalid_o};
    assign rdata_w[0] = bus0.data_rdata_o;
    assign rdata_w[1] = bus3.data_rdata_o;

`ifdef CGRA_RESP_RANGE_CHK_EN
    logic [1:0] err_w;
`endif

    cgra_col_mem_responder #(
        .MEM_DEPTH   (MEM_DEPTH),
        .GNT_LATENCY (0)
    ) u_dut0 (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus0)
`ifdef CGRA_RESP_RANGE_CHK_EN
        ,
        .range_err_o (err_w[0])
`endif
    );

    cgra_col_mem_responder #(
        .MEM_DEPTH   (MEM_DEPTH),
        .GNT_LATENCY (3)
    ) u_dut3 (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus3)
`ifdef CGRA_RESP_RANGE_CHK_EN
        ,
        .range_err_o (err_w[1])
`endif
    );

    // Reference model state, one entry per instance.
    logic [31:0] mem_m   [2][MEM_DEPTH];
    logic [31:0] ptr_m   [2];
    logic [31:0] rdata_m [2];
    logic        rvalid_m[2];
    logic        err_m   [2];
    int unsigned wait_m  [2];

    // Last sampled DUT outputs, for directed checks.
    logic        gnt_s   [2];
    logic        rvalid_s[2];
    logic [31:0] rdata_s [2];
    logic        err_s   [2];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int unsigned lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic addr_ok(input logic [31:0] a);
`ifdef CGRA_RESP_RANGE_CHK_EN
        return a < MEM_DEPTH * 4;
`else
        return 1'b1;
`endif
    endfunction

    // A request is granted once it has been held for GNT_LATENCY prior cycles.
    function automatic logic exp_gnt(input int d);
        return req && !rst && (wait_m[d] == lat_of(d));
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom();
        if ($urandom_range(0, 7) != 0) a = a % (MEM_DEPTH * 4);
        return a;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ptr_m[d]    = '0;
            rdata_m[d]  = '0;
            rvalid_m[d] = 1'b0;
            err_m[d]    = 1'b0;
            wait_m[d]   = 0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] a;
        int unsigned w;
        logic        inr;
        for (int d = 0; d < 2; d++) begin
            if (exp_gnt(d)) begin
                a   = ind ? add : ptr_m[d];
                w   = (a >> 2) % MEM_DEPTH;
                inr = addr_ok(a);
                if (wen) begin
                    rdata_m[d] = inr ? mem_m[d][w] : 32'h0;
                end else begin
                    rdata_m[d] = 32'h0;
                    if (inr) mem_m[d][w] = wdata;
                end
                rvalid_m[d] = 1'b1;
                wait_m[d]   = 0;
                if (!ind) ptr_m[d] = ptr_m[d] + 32'd4;
                if (!inr) err_m[d] = 1'b1;
            end else begin
                rvalid_m[d] = 1'b0;
                wait_m[d]   = req ? wait_m[d] + 1 : 0;
            end
            if (pload) ptr_m[d] = pval;
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic i, input logic [31:0] a,
                         input logic [31:0] wd, input logic pl, input logic [31:0] pv);
        req   = r;
        wen   = w;
        ind   = i;
        add   = a;
        wdata = wd;
        pload = pl;
        pval  = pv;
    endtask

    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            gnt_s[d]    = gnt_w[d];
            rvalid_s[d] = rvalid_w[d];
            rdata_s[d]  = rdata_w[d];
            check_eq($sformatf("gnt_d%0d", d), {31'b0, gnt_w[d]}, {31'b0, exp_gnt(d)});
            check_eq($sformatf("rvalid_d%0d", d), {31'b0, rvalid_w[d]}, {31'b0, rvalid_m[d]});
            check_eq($sformatf("rdata_d%0d", d), rdata_w[d], rdata_m[d]);
`ifdef CGRA_RESP_RANGE_CHK_EN
            err_s[d] = err_w[d];
            check_eq($sformatf("err_d%0d", d), {31'b0, err_w[d]}, {31'b0, err_m[d]});
`endif
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_gnt_d%0d", d), {31'b0, gnt_w[d]}, 32'h0);
            check_eq($sformatf("rst_rvalid_d%0d", d), {31'b0, rvalid_w[d]}, 32'h0);
            check_eq($sformatf("rst_rdata_d%0d", d), rdata_w[d], 32'h0);
`ifdef CGRA_RESP_RANGE_CHK_EN
            check_eq($sformatf("rst_err_d%0d", d), {31'b0, err_w[d]}, 32'h0);
`endif
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] va, vb, vc, vd, ve, vf, fill0;
        logic [3:0]  seen;
        int          hold;

        drive(0, 1, 1, 0, 0, 0, 0);
        pulse_reset();

        // Fill both memories; four-cycle holds let the latency-3 instance grant once per word.
        for (int w = 0; w < int'(MEM_DEPTH); w++) begin
            drive(1, 0, 1, w * 4, $urandom(), 0, 0);
            if (w == 0) fill0 = wdata;
            repeat (4) step();
        end
        drive(0, 1, 1, 0, 0, 0, 0);
        step();

        // Write then read back at 0x10 on consecutive cycles.
        drive(1, 0, 1, 32'h10, 32'h1234, 0, 0);
        step();
        seen[1] = gnt_s[0];
        drive(1, 1, 1, 32'h10, 32'h0, 0, 0);
        step();
        seen[0] = gnt_s[0];
        check_eq("wr_rd_gnts", {30'b0, seen[1:0]}, 32'h3);
        check_eq("wr_rvalid", {31'b0, rvalid_s[0]}, 32'h1);
        check_eq("wr_rdata_zero", rdata_s[0], 32'h0);
        drive(0, 1, 1, 0, 0, 0, 0);
        step();
        check_eq("rd_rvalid", {31'b0, rvalid_s[0]}, 32'h1);
        check_eq("rd_rdata", rdata_s[0], 32'h1234);

        // Pointer load, three pointer writes, indexed reads.
        va = $urandom(); vb = $urandom(); vc = $urandom(); ve = $urandom();
        drive(0, 1, 1, 0, 0, 1, 32'h20);
        step();
        drive(1, 0, 0, 0, va, 0, 0); step();
        drive(1, 0, 0, 0, vb, 0, 0); step();
        drive(1, 0, 0, 0, vc, 0, 0); step();
        drive(1, 1, 1, 32'h20, 0, 0, 0); step();
        drive(1, 1, 1, 32'h24, 0, 0, 0); step();
        check_eq("ptr_rd_a", rdata_s[0], va);
        drive(1, 1, 1, 32'h28, 0, 0, 0); step();
        check_eq("ptr_rd_b", rdata_s[0], vb);
        drive(1, 0, 0, 0, ve, 0, 0); step();
        check_eq("ptr_rd_c", rdata_s[0], vc);
        drive(1, 1, 1, 32'h2C, 0, 0, 0); step();
        drive(0, 1, 1, 0, 0, 0, 0); step();
        check_eq("ptr_at_2c", rdata_s[0], ve);

        // Pointer load colliding with a pointer write: write uses old pointer 0x30.
        vd = $urandom(); vf = $urandom();
        drive(1, 0, 0, 0, vd, 1, 32'h40); step();
        drive(1, 0, 0, 0, vf, 0, 0); step();
        drive(1, 1, 1, 32'h30, 0, 0, 0); step();
        drive(1, 1, 1, 32'h40, 0, 0, 0); step();
        check_eq("load_old_ptr", rdata_s[0], vd);
        drive(0, 1, 1, 0, 0, 0, 0); step();
        check_eq("load_wins", rdata_s[0], vf);

        // Latency 3: held request granted in its 4th cycle.
        drive(1, 1, 1, 32'h10, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            seen[i] = gnt_s[1];
        end
        check_eq("lat3_gnt_4th", {28'b0, seen}, 32'h8);
        drive(0, 1, 1, 0, 0, 0, 0); step();
        check_eq("lat3_rvalid", {31'b0, rvalid_s[1]}, 32'h1);
        // Abandoned after two cycles: no grant, no response.
        drive(1, 1, 1, 32'h10, 0, 0, 0);
        step(); seen[0] = gnt_s[1];
        step(); seen[1] = gnt_s[1];
        drive(0, 1, 1, 0, 0, 0, 0);
        step(); seen[2] = gnt_s[1];
        step(); seen[3] = rvalid_s[1];
        check_eq("lat3_abandon", {28'b0, seen}, 32'h0);
        drive(1, 1, 1, 32'h10, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            seen[i] = gnt_s[1];
        end
        check_eq("lat3_idle_again", {28'b0, seen}, 32'h8);

        // Reset in the cycle after a read grant kills the response.
        drive(1, 1, 1, 32'h10, 0, 0, 0);
        step();
        pulse_reset();
        drive(1, 1, 1, 32'h10, 0, 0, 0); step();
        drive(0, 1, 1, 0, 0, 0, 0); step();
        check_eq("post_rst_rvalid", {31'b0, rvalid_s[0]}, 32'h1);
        check_eq("post_rst_rdata", rdata_s[0], 32'h1234);

`ifdef CGRA_RESP_RANGE_CHK_EN
        drive(1, 0, 1, 32'h400, 32'hDEAD_BEEF, 0, 0); step();
        drive(0, 1, 1, 0, 0, 0, 0); step();
        check_eq("range_err_set", {31'b0, err_s[0]}, 32'h1);
        drive(1, 1, 1, 32'h400, 0, 0, 0); step();
        drive(1, 1, 1, 32'h0, 0, 0, 0); step();
        check_eq("range_rd_zero", rdata_s[0], 32'h0);
        drive(0, 1, 1, 0, 0, 0, 0); step();
        check_eq("range_mem_kept", rdata_s[0], fill0);
        check_eq("range_err_sticky", {31'b0, err_s[0]}, 32'h1);
        pulse_reset();
`else
        // Aliasing: 0x400 maps onto word 0.
        drive(1, 1, 1, 32'h400, 0, 0, 0); step();
        drive(0, 1, 1, 0, 0, 0, 0); step();
        check_eq("alias_rd", rdata_s[0], fill0);
`endif

        // Randomized traffic with occasional pointer loads and resets.
        repeat (300) begin
            if ($urandom_range(0, 39) == 0) pulse_reset();
            hold = $urandom_range(1, 5);
            drive(1, $urandom_range(0, 1), $urandom_range(0, 1), rand_addr(), $urandom(), 0, 0);
            for (int h = 0; h < hold; h++) begin
                pload = ($urandom_range(0, 7) == 0);
                pval  = rand_addr();
                step();
            end
            if ($urandom_range(0, 1) != 0) begin
                drive(0, 1, 1, 0, 0, 0, 0);
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
